// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared states, limits and index-width helper for the data-memory responder
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  // Word-index width for a given array depth (depth is a power of two)
  function automatic int idx_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with synchronous write and combinational read
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = idx_width(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Write port; no reset so contents survive a pipeline reset
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency MEM-stage load/store responder with request validation
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int IDX_W = idx_width(DEPTH_WORDS);

  if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dmem_responder: LATENCY out of range");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        data_q, data_d;
  logic               wr_q, wr_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;

  logic               req, bad, acc_go, acc_wr, mem_we;
  logic [IDX_W-1:0]   acc_idx;
  logic [31:0]        acc_wdata, rdata;

  assign req = MemRead_i | MemWrite_i;
  assign bad = (addr_i[1:0] != 2'b00) ||
               (addr_i[31:2] >= 30'(DEPTH_WORDS)) ||
               (MemRead_i & MemWrite_i);

  // In IDLE the live request feeds the array (single-cycle access); later states use the captured one
  assign acc_idx   = (state_q == IDLE) ? addr_i[IDX_W+1:2] : idx_q;
  assign acc_wdata = (state_q == IDLE) ? data_i : wdata_q;
  assign acc_wr    = (state_q == IDLE) ? MemWrite_i : wr_q;
  assign mem_we    = acc_go & acc_wr;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .addr_i  (acc_idx),
    .wdata_i (acc_wdata),
    .rdata_o (rdata)
  );

  // Next-state: validate and capture in IDLE, count down in ACCESS, one-cycle completion in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    data_d  = data_q;
    ack_d   = 1'b0;
    acc_go  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = DONE;
          ack_d   = 1'b1;
          if (bad) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            idx_d   = addr_i[IDX_W+1:2];
            wdata_d = data_i;
            wr_d    = MemWrite_i;
            if (LATENCY == 1) begin
              acc_go = 1'b1;
            end else begin
              cnt_d   = CNT_W'(LATENCY - 1);
              state_d = ACCESS;
              ack_d   = 1'b0;
            end
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          acc_go  = 1'b1;
          state_d = DONE;
          ack_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (acc_go && !acc_wr) data_d = rdata;
  end

  // State and captured-request registers; reset drops any outstanding request
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign stall_o = ((state_q == IDLE) && req) || (state_q == ACCESS);
  assign data_o  = data_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at LATENCY 3 and LATENCY 1
module tb_dmem_responder;

  localparam int LAT0 = 3;
  localparam int DEP0 = 256;
  localparam int LAT1 = 1;
  localparam int DEP1 = 16;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i;
  logic        rd0, wr0, st0, ack0, er0;
  logic [31:0] a0, d0, q0;
  logic        rd1, wr1, st1, ack1, er1;
  logic [31:0] a1, d1, q1;

  dmem_responder #(.DEPTH_WORDS(DEP0), .LATENCY(LAT0)) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(rd0), .MemWrite_i(wr0),
    .addr_i(a0), .data_i(d0), .data_o(q0), .stall_o(st0), .ack_o(ack0), .err_o(er0)
  );

  dmem_responder #(.DEPTH_WORDS(DEP1), .LATENCY(LAT1)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(rd1), .MemWrite_i(wr1),
    .addr_i(a1), .data_i(d1), .data_o(q1), .stall_o(st1), .ack_o(ack1), .err_o(er1)
  );

  int checks   = 0;
  int failures = 0;
  int sel      = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl0 [DEP0];
  logic [31:0] mdl1 [DEP1];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;

  logic        stall_s, ack_s, err_s;
  logic [31:0] q_s;
  assign stall_s = (sel == 0) ? st0  : st1;
  assign ack_s   = (sel == 0) ? ack0 : ack1;
  assign err_s   = (sel == 0) ? er0  : er1;
  assign q_s     = (sel == 0) ? q0   : q1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      rd0 = rd; wr0 = wr; a0 = a; d0 = d;
    end else begin
      rd1 = rd; wr1 = wr; a1 = a; d1 = d;
    end
  endtask

  task automatic request(input string tag, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    int          dep, lat, n, ns;
    logic        bad;
    logic [31:0] idx;
    exp_t        e;
    dep = (sel == 0) ? DEP0 : DEP1;
    lat = (sel == 0) ? LAT0 : LAT1;
    idx = {2'b00, a[31:2]};
    bad = (a[1:0] != 2'b00) || (idx >= 32'(dep)) || (rd && wr);
    e.err = bad;
    if (sel == 0) begin
      if (!bad && wr) mdl0[idx] = d;
      if (!bad && rd) last0 = mdl0[idx];
      e.data = last0;
    end else begin
      if (!bad && wr) mdl1[idx] = d;
      if (!bad && rd) last1 = mdl1[idx];
      e.data = last1;
    end
    sb.push_back(e);

    @(posedge clk_i); #1;
    drive(rd, wr, a, d);
    n  = 0;
    ns = 0;
    @(negedge clk_i);
    while (!ack_s && n < 40) begin
      if (stall_s) ns++;
      n++;
      @(negedge clk_i);
    end
    check_eq({tag, ":latency"}, n, bad ? 1 : lat);
    check_eq({tag, ":stall_cycles"}, ns, bad ? 1 : lat);
    check_eq({tag, ":stall_at_ack"}, stall_s, 1'b0);
    drive(1'b0, 1'b0, '0, '0);
    e = sb.pop_front();
    check_eq({tag, ":err"}, err_s, e.err);
    check_eq({tag, ":data"}, q_s, e.data);
    @(negedge clk_i);
    check_eq({tag, ":ack_pulse"}, ack_s, 1'b0);
  endtask

  initial begin
    rst_i = 1'b0;
    rd0 = 0; wr0 = 0; a0 = '0; d0 = '0;
    rd1 = 0; wr1 = 0; a1 = '0; d1 = '0;
    repeat (3) @(negedge clk_i);
    check_eq("reset:data", q0, 32'h0);
    check_eq("reset:ack", ack0, 1'b0);
    check_eq("reset:err", er0, 1'b0);
    check_eq("reset:stall", st0, 1'b0);
    rst_i = 1'b1;

    sel = 0;
    request("st_10",   1'b0, 1'b1, 32'h10,  32'hDEADBEEF);
    request("ld_10",   1'b1, 1'b0, 32'h10,  32'h0);
    request("st_00",   1'b0, 1'b1, 32'h00,  32'h11111111);
    request("ld_mis",  1'b1, 1'b0, 32'h13,  32'h0);
    request("st_oor",  1'b0, 1'b1, 32'h400, 32'hBADBAD00);
    request("ld_00",   1'b1, 1'b0, 32'h00,  32'h0);
    request("both",    1'b1, 1'b1, 32'h00,  32'hBAD0BAD0);
    request("ld_00b",  1'b1, 1'b0, 32'h00,  32'h0);
    request("st_top",  1'b0, 1'b1, 32'h3FC, 32'hA5A5C3C3);
    request("ld_top",  1'b1, 1'b0, 32'h3FC, 32'h0);

    request("st_20",   1'b0, 1'b1, 32'h20,  32'hCAFEF00D);
    @(posedge clk_i); #1;
    drive(1'b0, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk_i);
    check_eq("rst_mid:stall_T", st0, 1'b1);
    @(negedge clk_i);
    check_eq("rst_mid:stall_access", st0, 1'b1);
    rst_i = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    #1;
    check_eq("rst_mid:ack", ack0, 1'b0);
    check_eq("rst_mid:data", q0, 32'h0);
    check_eq("rst_mid:stall", st0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    last0 = '0;
    last1 = '0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_mid:no_ack", ack0, 1'b0);
    request("ld_20",   1'b1, 1'b0, 32'h20,  32'h0);

    sel = 1;
    request("l1_st_04", 1'b0, 1'b1, 32'h04, 32'h0BADF00D);
    request("l1_ld_04", 1'b1, 1'b0, 32'h04, 32'h0);
    request("l1_oor",   1'b1, 1'b0, 32'h40, 32'h0);
    request("l1_mis",   1'b0, 1'b1, 32'h06, 32'h77777777);
    request("l1_ld_04b",1'b1, 1'b0, 32'h04, 32'h0);

    check_eq("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
